// File: rtl/acl_cfg_pkg.sv
// Shared types for the ACL threshold/timer configuration sequencer: command codes,
// FSM states and counter widths.
package acl_cfg_pkg;

  typedef enum logic [1:0] {
    CMD_STOP      = 2'd0,
    CMD_WR_THRESH = 2'd1,
    CMD_WR_TIMER  = 2'd2,
    CMD_START     = 2'd3
  } t_acl_cmd;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_ERROR     = 3'd3,
    ST_SETTLE    = 3'd4
  } t_cfgseq_state;

  localparam int TIMEOUT_CNT_W = 16;
  localparam int RETRY_CNT_W   = 3;

  // STOP and START carry no payload.
  function automatic logic [15:0] cmd_payload(input t_acl_cmd cmd,
                                              input logic [15:0] thresh,
                                              input logic [15:0] timer);
    case (cmd)
      CMD_WR_THRESH: return thresh;
      CMD_WR_TIMER:  return timer;
      default:       return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// Up-counter with synchronous clear and enable; tc is high once the count equals TERM.
// The count saturates at TERM so a held enable never wraps back below the terminal value.
module cfg_timeout_counter #(
  parameter int CNT_W = 16,
  parameter int TERM  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(TERM));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acl_thresh_cfg_sequencer.sv
// Replays STOP/WR_THRESH/WR_TIMER/START to the ACL driver whenever the preset changes; 9 cycles minimum
// per sequence, waits on i_cmd_ready indefinitely, retries on done timeout. THRPSET_SETTLE_EN adds input settling.
module acl_thresh_cfg_sequencer
  import acl_cfg_pkg::*;
#(
  parameter int parm_done_timeout = 20000,
  parameter int parm_max_retries  = 3
`ifdef THRPSET_SETTLE_EN
  ,
  parameter int parm_settle_cycles = 200000
`endif
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz_n,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  output logic        o_cmd_valid,
  output logic [1:0]  o_cmd_code,
  output logic [15:0] o_cmd_data,
  input  logic        i_cmd_ready,
  input  logic        i_cmd_done,
  input  logic        i_err_clr,
  output logic        o_busy,
  output logic        o_err,
  output logic [3:0]  o_applied_enum
);

  t_cfgseq_state          state_q, state_d;
  t_acl_cmd               step_q, step_d;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d;
  logic                   init_pend_q, init_pend_d;
  logic [3:0]             snap_enum_q, snap_enum_d;
  logic [15:0]            snap_thresh_q, snap_thresh_d;
  logic [15:0]            snap_timer_q, snap_timer_d;
  logic [3:0]             applied_q, applied_d;

  logic accept, trigger, take_snap;
  logic tmo_clr, tmo_en, tmo_tc;

  assign accept  = (state_q == ST_ISSUE) && i_cmd_ready;
  assign trigger = init_pend_q || (i_value_enum != applied_q);

  cfg_timeout_counter #(
    .CNT_W (TIMEOUT_CNT_W),
    .TERM  (parm_done_timeout - 1)
  ) u_done_tmo (
    .clk   (i_clk_20mhz),
    .rst_n (i_rst_20mhz_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

`ifdef THRPSET_SETTLE_EN
  localparam int SETTLE_CNT_W = 24;

  logic [3:0] enum_prev_q, enum_prev_d;
  logic       settle_clr, settle_en, settle_tc;

  assign enum_prev_d = i_value_enum;

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      enum_prev_q <= 4'd0;
    end else begin
      enum_prev_q <= enum_prev_d;
    end
  end

  cfg_timeout_counter #(
    .CNT_W (SETTLE_CNT_W),
    .TERM  (parm_settle_cycles - 1)
  ) u_settle_cnt (
    .clk   (i_clk_20mhz),
    .rst_n (i_rst_20mhz_n),
    .clr   (settle_clr),
    .en    (settle_en),
    .tc    (settle_tc)
  );
`endif

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    retry_d       = retry_q;
    init_pend_d   = init_pend_q;
    applied_d     = applied_q;
    snap_enum_d   = snap_enum_q;
    snap_thresh_d = snap_thresh_q;
    snap_timer_d  = snap_timer_q;
    take_snap     = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;
`ifdef THRPSET_SETTLE_EN
    settle_clr    = 1'b0;
    settle_en     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
`ifdef THRPSET_SETTLE_EN
          state_d    = ST_SETTLE;
          settle_clr = 1'b1;
`else
          take_snap  = 1'b1;
`endif
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          tmo_clr = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmo_en = 1'b1;
        // A done landing on the terminal cycle still completes the command.
        if (i_cmd_done) begin
          retry_d = '0;
          if (step_q == CMD_START) begin
            applied_d = snap_enum_q;
            state_d   = ST_IDLE;
          end else begin
            step_d  = t_acl_cmd'(step_q + 2'd1);
            state_d = ST_ISSUE;
          end
        end else if (tmo_tc) begin
          if (retry_q < RETRY_CNT_W'(parm_max_retries)) begin
            retry_d = retry_q + RETRY_CNT_W'(1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (i_err_clr) begin
          init_pend_d = 1'b1;
          retry_d     = '0;
          state_d     = ST_IDLE;
        end
      end
`ifdef THRPSET_SETTLE_EN
      ST_SETTLE: begin
        settle_en = 1'b1;
        if (!init_pend_q && (i_value_enum == applied_q)) begin
          state_d = ST_IDLE;
        end else if (i_value_enum != enum_prev_q) begin
          settle_clr = 1'b1;
        end else if (settle_tc) begin
          take_snap = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (take_snap) begin
      snap_enum_d   = i_value_enum;
      snap_thresh_d = i_value_thresh;
      snap_timer_d  = i_value_timer;
      init_pend_d   = 1'b0;
      retry_d       = '0;
      step_d        = CMD_STOP;
      state_d       = ST_ISSUE;
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      state_q       <= ST_IDLE;
      step_q        <= CMD_STOP;
      retry_q       <= '0;
      init_pend_q   <= 1'b1;
      snap_enum_q   <= 4'd0;
      snap_thresh_q <= 16'h0000;
      snap_timer_q  <= 16'h0000;
      applied_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      retry_q       <= retry_d;
      init_pend_q   <= init_pend_d;
      snap_enum_q   <= snap_enum_d;
      snap_thresh_q <= snap_thresh_d;
      snap_timer_q  <= snap_timer_d;
      applied_q     <= applied_d;
    end
  end

  // Code and data follow the step and snapshot, so they cannot move while valid waits on ready.
  assign o_cmd_valid    = (state_q == ST_ISSUE);
  assign o_cmd_code     = step_q;
  assign o_cmd_data     = cmd_payload(step_q, snap_thresh_q, snap_timer_q);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_err          = (state_q == ST_ERROR);
  assign o_applied_enum = applied_q;

endmodule

// File: tb/tb_acl_thresh_cfg_sequencer.sv
// Randomized bench for acl_thresh_cfg_sequencer: a command-stream model is compared every cycle,
// with directed scenarios pinning ordering, latency, stall, retry/error and reset behaviour.
module tb_acl_thresh_cfg_sequencer;

  localparam int T = 16;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_value_enum = 4'd0;
  logic [15:0] i_value_thresh = 16'h0;
  logic [15:0] i_value_timer = 16'h0;
  logic        o_cmd_valid;
  logic [1:0]  o_cmd_code;
  logic [15:0] o_cmd_data;
  logic        i_cmd_ready = 1'b1;
  logic        i_cmd_done = 1'b0;
  logic        i_err_clr = 1'b0;
  logic        o_busy;
  logic        o_err;
  logic [3:0]  o_applied_enum;

  acl_thresh_cfg_sequencer #(
    .parm_done_timeout (T),
    .parm_max_retries  (R)
  ) dut (
    .i_clk_20mhz    (clk),
    .i_rst_20mhz_n  (rst_n),
    .i_value_enum   (i_value_enum),
    .i_value_thresh (i_value_thresh),
    .i_value_timer  (i_value_timer),
    .o_cmd_valid    (o_cmd_valid),
    .o_cmd_code     (o_cmd_code),
    .o_cmd_data     (o_cmd_data),
    .i_cmd_ready    (i_cmd_ready),
    .i_cmd_done     (i_cmd_done),
    .i_err_clr      (i_err_clr),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_applied_enum (o_applied_enum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [15:0] data;
  } cmd_t;

  logic [15:0] th_tab[16];
  logic [15:0] tm_tab[16];

  task automatic set_enum(input logic [3:0] e);
    i_value_enum   = e;
    i_value_thresh = th_tab[e];
    i_value_timer  = tm_tab[e];
  endtask

  // Model: the sequence is a queue of commands still owed to the driver.
  cmd_t       m_q[$];
  bit         m_inflight = 0;
  bit         m_err = 0;
  bit         m_pend = 1;
  int         m_wait = 0;
  int         m_tries = 0;
  logic [3:0] m_applied = 4'd0;
  logic [3:0] m_seq = 4'd0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_inflight = 0; m_err = 0; m_pend = 1; m_wait = 0; m_tries = 0;
      m_applied = 4'd0; m_seq = 4'd0;
    end else if (m_err) begin
      if (i_err_clr) begin
        m_err  = 0;
        m_pend = 1;
      end
    end else if (m_q.size() == 0) begin
      if (m_pend || (i_value_enum != m_applied)) begin
        m_seq = i_value_enum; m_pend = 0; m_tries = 0;
        m_q.push_back('{code: 2'd0, data: 16'h0000});
        m_q.push_back('{code: 2'd1, data: i_value_thresh});
        m_q.push_back('{code: 2'd2, data: i_value_timer});
        m_q.push_back('{code: 2'd3, data: 16'h0000});
      end
    end else if (!m_inflight) begin
      if (i_cmd_ready) begin
        m_inflight = 1;
        m_wait = 0;
      end
    end else if (i_cmd_done) begin
      void'(m_q.pop_front());
      m_inflight = 0;
      m_tries = 0;
      if (m_q.size() == 0) m_applied = m_seq;
    end else begin
      m_wait++;
      if (m_wait == T) begin
        m_inflight = 0;
        if (m_tries < R) m_tries++;
        else begin
          m_err = 1;
          m_q.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model, on the falling edge.
  logic        seen_valid = 1'b0;
  logic [1:0]  seen_code = 2'd0;
  logic [15:0] seen_data = 16'h0;

  initial forever begin
    bit exp_valid;
    @(negedge clk);
    exp_valid = (m_q.size() != 0) && !m_inflight && !m_err;
    chk("cyc_valid", o_cmd_valid, exp_valid);
    chk("cyc_busy", o_busy, (m_q.size() != 0) || m_err);
    chk("cyc_err", o_err, m_err);
    chk("cyc_applied", o_applied_enum, m_applied);
    if (exp_valid) begin
      chk("cyc_code", o_cmd_code, 4 - m_q.size());
      chk("cyc_data", o_cmd_data, m_q[0].data);
    end
    seen_valid = o_cmd_valid;
    seen_code  = o_cmd_code;
    seen_data  = o_cmd_data;
  end

  // ACL driver stand-in: ready pattern, done after a delay, optional stray and suppressed dones.
  int   ready_mode = 0;
  int   dly_min = 3;
  int   dly_max = 3;
  bit   stray_en = 0;
  bit   sup_en = 0;
  logic [1:0] sup_code = 2'd0;
  int   done_cd = 0;
  int   cyc = 0;
  cmd_t log_q[$];
  int   log_cyc[$];

  initial forever begin
    bit acc;
    @(posedge clk);
    #1;
    cyc++;
    acc = seen_valid && i_cmd_ready && rst_n;
    i_cmd_done = 1'b0;
    if (!rst_n) begin
      done_cd = 0;
    end else begin
      if (acc) begin
        log_q.push_back('{code: seen_code, data: seen_data});
        log_cyc.push_back(cyc);
        if (sup_en && seen_code == sup_code) done_cd = 0;
        else done_cd = $urandom_range(dly_max, dly_min);
      end
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) i_cmd_done = 1'b1;
      end
      if (stray_en && !i_cmd_done && $urandom_range(0, 29) == 0) i_cmd_done = 1'b1;
    end
    case (ready_mode)
      0:       i_cmd_ready = 1'b1;
      1:       i_cmd_ready = ($urandom_range(0, 3) != 0);
      default: i_cmd_ready = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    repeat (2) step();
    while (!(o_busy == 1'b0 && o_applied_enum == i_value_enum) && n < budget) begin
      step();
      n++;
    end
    chk(nm, n < budget, 1);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic chk_seq(input string nm, input int base, input logic [15:0] th, input logic [15:0] tm);
    chk({nm, "_c0"}, log_q[base].code, 0);
    chk({nm, "_d0"}, log_q[base].data, 16'h0000);
    chk({nm, "_c1"}, log_q[base+1].code, 1);
    chk({nm, "_d1"}, log_q[base+1].data, th);
    chk({nm, "_c2"}, log_q[base+2].code, 2);
    chk({nm, "_d2"}, log_q[base+2].data, tm);
    chk({nm, "_c3"}, log_q[base+3].code, 3);
    chk({nm, "_d3"}, log_q[base+3].data, 16'h0000);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int tcyc[$];
    logic [3:0] e;
    for (int k = 0; k < 16; k++) begin
      th_tab[k] = 16'($urandom);
      tm_tab[k] = 16'($urandom);
    end
    th_tab[0] = 16'h0100; tm_tab[0] = 16'h0020;
    th_tab[3] = 16'h0300; tm_tab[3] = 16'h0030;
    th_tab[5] = 16'h0400; tm_tab[5] = 16'h0050;
    th_tab[6] = 16'h0600; tm_tab[6] = 16'h0060;
    th_tab[7] = 16'h0700; tm_tab[7] = 16'h0070;
    set_enum(4'd0);

    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_code", o_cmd_code, 0);
    chk("rst_data", o_cmd_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_applied", o_applied_enum, 0);

    // Initial apply after reset, enum 0.
    step();
    clear_log();
    rst_n = 1'b1;
    wait_idle(200, "init_timeout");
    chk("init_count", log_q.size(), 4);
    if (log_q.size() >= 4) chk_seq("init", 0, 16'h0100, 16'h0020);
    chk("init_applied", o_applied_enum, 0);
    chk("init_busy", o_busy, 0);

    // Single preset change.
    clear_log();
    set_enum(4'd5);
    wait_idle(200, "p5_timeout");
    chk("p5_count", log_q.size(), 4);
    if (log_q.size() >= 4) chk_seq("p5", 0, 16'h0400, 16'h0050);
    chk("p5_applied", o_applied_enum, 5);

    // Change 6 then 7 during WR_THRESH: snapshot holds 6, then a 7 sequence follows.
    clear_log();
    set_enum(4'd6);
    n = 0;
    while (!(o_cmd_valid && o_cmd_code == 2'd1) && n < 100) begin
      step();
      n++;
    end
    chk("p67_wait_thresh", n < 100, 1);
    set_enum(4'd7);
    wait_idle(400, "p67_timeout");
    chk("p67_count", log_q.size(), 8);
    if (log_q.size() >= 8) begin
      chk_seq("p67_a", 0, 16'h0600, 16'h0060);
      chk_seq("p67_b", 4, 16'h0700, 16'h0070);
    end
    chk("p67_applied", o_applied_enum, 7);

    // Minimum latency: ready always high, done one cycle after accept.
    dly_min = 1; dly_max = 1;
    set_enum(4'd4);
    n = 0;
    while (o_applied_enum != 4'd4 && n < 50) begin
      step();
      n++;
    end
    chk("latency_cycles", n, 9);
    dly_min = 3; dly_max = 3;
    wait_idle(100, "latency_idle");

    // Ready held low for 1000 cycles in ISSUE.
    clear_log();
    ready_mode = 2;
    set_enum(4'd2);
    n = 0;
    while (!o_cmd_valid && n < 20) begin
      step();
      n++;
    end
    chk("stall_wait_valid", n < 20, 1);
    repeat (1000) step();
    chk("stall_valid", o_cmd_valid, 1);
    chk("stall_code", o_cmd_code, 0);
    chk("stall_data", o_cmd_data, 0);
    chk("stall_err", o_err, 0);
    chk("stall_accepts", log_q.size(), 0);
    ready_mode = 0;
    wait_idle(200, "stall_timeout");
    chk("stall_count", log_q.size(), 4);
    chk("stall_applied", o_applied_enum, 2);

    // WR_TIMER never completes: 1 issue + R retries, then ERROR.
    clear_log();
    sup_en = 1; sup_code = 2'd2;
    set_enum(4'd3);
    n = 0;
    while (!o_err && n < 400) begin
      step();
      n++;
    end
    chk("tmo_wait_err", n < 400, 1);
    chk("tmo_err", o_err, 1);
    chk("tmo_valid", o_cmd_valid, 0);
    chk("tmo_applied", o_applied_enum, 2);
    tcyc.delete();
    foreach (log_q[k]) if (log_q[k].code == 2'd2) tcyc.push_back(log_cyc[k]);
    chk("tmo_timer_issues", tcyc.size(), 3);
    // Each re-issue follows T wait cycles plus one cycle back in ISSUE.
    for (int k = 1; k < tcyc.size(); k++) chk("tmo_interval", tcyc[k] - tcyc[k-1], 17);
    sup_en = 0;
    repeat (5) step();
    chk("tmo_err_held", o_err, 1);
    clear_log();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    wait_idle(200, "errclr_timeout");
    chk("errclr_err", o_err, 0);
    chk("errclr_count", log_q.size(), 4);
    if (log_q.size() >= 4) chk_seq("errclr", 0, 16'h0300, 16'h0030);
    chk("errclr_applied", o_applied_enum, 3);

    // Reset while waiting for STOP done.
    clear_log();
    set_enum(4'd9);
    n = 0;
    while (log_q.size() == 0 && n < 50) begin
      step();
      n++;
    end
    chk("rstmid_wait_accept", n < 50, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", o_cmd_valid, 0);
    chk("rstmid_code", o_cmd_code, 0);
    chk("rstmid_data", o_cmd_data, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_err", o_err, 0);
    chk("rstmid_applied", o_applied_enum, 0);
    repeat (3) step();
    clear_log();
    rst_n = 1'b1;
    wait_idle(200, "rstmid_timeout");
    chk("rstmid_count", log_q.size(), 4);
    if (log_q.size() >= 4) chk_seq("rstmid", 0, th_tab[9], tm_tab[9]);
    chk("rstmid_reapplied", o_applied_enum, 9);

    // Randomized traffic: random ready, done delays, stray dones, stray error clears.
    ready_mode = 1; stray_en = 1; dly_min = 1; dly_max = 6;
    for (int it = 0; it < 60; it++) begin
      e = 4'($urandom_range(0, 15));
      set_enum(e);
      if ($urandom_range(0, 7) == 0) i_err_clr = 1'b1;
      step();
      i_err_clr = 1'b0;
      repeat ($urandom_range(0, 30)) step();
    end
    wait_idle(3000, "rand_timeout");
    chk("rand_final_applied", o_applied_enum, e);
    chk("rand_final_err", o_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
